// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the arbiter FSM state type.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } arb_state_t;

  // Low-address bits that must be zero for a transfer of 2^size bytes.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    return ~(8'hFF << size);
  endfunction

endpackage

// File: rtl/ahb3lite_sram_arbiter_arb.sv
// Two-client round-robin grant: a lone requester wins, otherwise the client
// that did not win the previous grant.
module ahb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       update,
  output logic       gnt
);

  logic last_gnt;

  // Grant decision from the current requests and the previous winner
  always_comb begin
    gnt = ~last_gnt;
    if (req_valid == 2'b01) begin
      gnt = 1'b0;
    end else if (req_valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

  // Remember the winner; reset to 1 so client 0 wins the first contest
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (update) begin
      last_gnt <= gnt;
    end
  end

endmodule

// File: rtl/ahb3lite_sram_arbiter.sv
// AHB3-Lite master front end sharing one SRAM slave between two request/done
// clients. One SINGLE transfer at a time; misaligned or oversize requests are
// answered locally without touching the bus.
module ahb3lite_sram_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [1:0][HADDR_SIZE-1:0]  req_addr,
  input  logic [1:0][2:0]             req_size,
  input  logic [1:0][HDATA_SIZE-1:0]  req_wdata,
  output logic [1:0]                  req_done,
  output logic                        req_err,
  output logic [HDATA_SIZE-1:0]       req_rdata,
  output logic [HADDR_SIZE-1:0]       HADDR,
  output logic [1:0]                  HTRANS,
  output logic                        HWRITE,
  output logic [2:0]                  HSIZE,
  output logic [2:0]                  HBURST,
  output logic [3:0]                  HPROT,
  output logic [HDATA_SIZE-1:0]       HWDATA,
  input  logic [HDATA_SIZE-1:0]       HRDATA,
  input  logic                        HREADY,
  input  logic                        HRESP
);

  // Largest legal HSIZE for the data bus width (2 for 32 bit, 3 for 64 bit).
  localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

  arb_state_t             state;
  htrans_t                htrans_q;
  logic                   gnt;
  logic                   gnt_q;
  logic                   arb_update;
  logic [HDATA_SIZE-1:0]  wdata_q;

  function automatic logic is_illegal(input logic [2:0] size, input logic [7:0] addr_lo);
    return (size > MAX_SIZE) || ((addr_lo & size_mask(size)) != 8'd0);
  endfunction

  function automatic logic [1:0] onehot(input logic client);
    return client ? 2'b10 : 2'b01;
  endfunction

  assign arb_update = (state == ST_IDLE) && (|req_valid);

  ahb_rr_arb2 u_arb (
    .clk       (HCLK),
    .rst       (HRESET),
    .req_valid (req_valid),
    .update    (arb_update),
    .gnt       (gnt)
  );

  assign HTRANS = htrans_q;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DEFAULT;

  // Arbitration / transfer FSM; every bus and client output is a register here
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      htrans_q  <= IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      req_done  <= 2'b00;
      req_err   <= 1'b0;
      req_rdata <= '0;
      gnt_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt_q <= gnt;
            if (is_illegal(req_size[gnt], req_addr[gnt][7:0])) begin
              // Answer immediately; the bus never sees this request.
              req_done <= onehot(gnt);
              req_err  <= 1'b1;
              state    <= ST_RESP;
            end else begin
              HADDR    <= req_addr[gnt];
              HSIZE    <= req_size[gnt];
              HWRITE   <= req_write[gnt];
              wdata_q  <= req_wdata[gnt];
              htrans_q <= NONSEQ;
              state    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            htrans_q <= IDLE;
            HWDATA   <= wdata_q;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          // First ERROR cycle has HREADY low and simply extends this state.
          if (HREADY) begin
            if (!HWRITE) begin
              req_rdata <= HRDATA;
            end
            req_err  <= HRESP;
            req_done <= onehot(gnt_q);
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_done <= 2'b00;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Directed bench for ahb3lite_sram_arbiter with a small behavioural SRAM slave
// that supports programmable data-phase wait states and two-cycle ERRORs.
module tb_ahb3lite_sram_arbiter;
  import ahb3lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic                 HCLK = 1'b0;
  logic                 HRESET;
  logic [1:0]           req_valid;
  logic [1:0]           req_write;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][2:0]      req_size;
  logic [1:0][DW-1:0]   req_wdata;
  logic [1:0]           req_done;
  logic                 req_err;
  logic [DW-1:0]        req_rdata;
  logic [AW-1:0]        HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [3:0]           HPROT;
  logic [DW-1:0]        HWDATA;
  logic [DW-1:0]        HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_arbiter #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  // ---------------- behavioural slave ----------------
  int          wait_cfg = 0;
  logic        err_cfg  = 1'b0;
  logic [31:0] mem [16];
  logic        dp_active, dp_write, dp_err, err2;
  logic [AW-1:0] dp_addr;
  logic [2:0]  dp_size;
  int          wait_cnt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [2:0] sz);
    logic [3:0]  be;
    logic [31:0] r;
    case (sz)
      3'd0:    be = 4'b0001 << a;
      3'd1:    be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = mem[dp_addr[5:2]];
    if (dp_active) begin
      if (wait_cnt != 0) begin
        HREADY = 1'b0;
      end else if (dp_err) begin
        HRESP  = 1'b1;
        HREADY = err2;
      end
    end
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_err    <= 1'b0;
      err2      <= 1'b0;
      dp_addr   <= '0;
      dp_size   <= '0;
      wait_cnt  <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (dp_active) begin
        if (wait_cnt != 0) begin
          wait_cnt <= wait_cnt - 1;
        end else if (dp_err && !err2) begin
          err2 <= 1'b1;
        end else begin
          if (dp_write && !dp_err)
            mem[dp_addr[5:2]] <= merge(mem[dp_addr[5:2]], HWDATA, dp_addr[1:0], dp_size);
          dp_active <= 1'b0;
        end
      end
      if (HREADY && HTRANS == NONSEQ) begin
        dp_active <= 1'b1;
        dp_addr   <= HADDR;
        dp_write  <= HWRITE;
        dp_size   <= HSIZE;
        wait_cnt  <= wait_cfg;
        dp_err    <= err_cfg;
        err2      <= 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  int nonseq_cnt  = 0;
  int overlap_cnt = 0;
  always @(posedge HCLK) begin
    if (HTRANS == NONSEQ) nonseq_cnt <= nonseq_cnt + 1;
    if (req_done == 2'b11) overlap_cnt <= overlap_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        client;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          wt;
    logic        er;
    int          lat;
    logic        exp_err;
    logic        bus;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input int idx);
    vec_t v;
    int   k;
    int   n0;
    v = vecs[idx];
    @(negedge HCLK);
    wait_cfg = v.wt;
    err_cfg  = v.er;
    req_write[v.client] = v.write;
    req_addr[v.client]  = v.addr;
    req_size[v.client]  = v.size;
    req_wdata[v.client] = v.wdata;
    req_valid = v.client ? 2'b10 : 2'b01;
    n0 = nonseq_cnt;
    k  = 0;
    while (k < 20 && req_done == 2'b00) begin
      @(posedge HCLK);
      #1;
      k++;
    end
    check($sformatf("vec%0d latency", idx), 32'(k), 32'(v.lat));
    check($sformatf("vec%0d done", idx), 32'(req_done), v.client ? 32'd2 : 32'd1);
    check($sformatf("vec%0d err", idx), 32'(req_err), 32'(v.exp_err));
    if (v.chk_rd) check($sformatf("vec%0d rdata", idx), req_rdata, v.rd);
    check($sformatf("vec%0d nonseq_seen", idx), 32'(nonseq_cnt != n0), 32'(v.bus));
    req_valid = 2'b00;
    @(posedge HCLK);
  endtask

  initial begin
    int cyc;
    int ndone;
    int last_cyc;
    int cnt0;
    int cnt1;
    int ov0;
    logic [1:0] exp_done;
    logic saw_done;

    //        cl    wr    addr          size         wdata        wt er   lat err  bus  chk  rd
    vecs[0]  = '{1'b0, 1'b1, 32'h0, HSIZE_WORD,  32'hDEADBEEF, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, HSIZE_WORD,  32'h0,        0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h2, HSIZE_BYTE,  32'h00A50000, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, HSIZE_WORD,  32'h0,        0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 32'hDEA5BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h1, HSIZE_HWORD, 32'h0,        0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 32'hDEA5BEEF};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, HSIZE_DWORD, 32'h0,        0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 32'hDEA5BEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'h4, HSIZE_WORD,  32'h12345678, 2, 1'b0, 5, 1'b0, 1'b1, 1'b1, 32'hDEA5BEEF};
    vecs[7]  = '{1'b0, 1'b0, 32'h4, HSIZE_WORD,  32'h0,        2, 1'b0, 5, 1'b0, 1'b1, 1'b1, 32'h12345678};
    vecs[8]  = '{1'b1, 1'b0, 32'h0, HSIZE_WORD,  32'h0,        0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 32'hDEA5BEEF};
    vecs[9]  = '{1'b0, 1'b1, 32'h8, HSIZE_WORD,  32'h11111111, 0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h6, HSIZE_HWORD, 32'h0,        0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 32'h12345678};
    vecs[11] = '{1'b0, 1'b1, 32'h6, HSIZE_HWORD, 32'hCAFE0000, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h4, HSIZE_WORD,  32'h0,        0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 32'hCAFE5678};

    HRESET    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset htrans", 32'(HTRANS), 32'(IDLE));
    check("reset haddr", HADDR, 32'h0);
    check("reset hwdata", HWDATA, 32'h0);
    check("reset done", 32'(req_done), 32'h0);
    check("reset rdata", req_rdata, 32'h0);
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Round robin with both clients requesting continuously from reset.
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    wait_cfg = 0;
    err_cfg  = 1'b0;
    req_write = 2'b00;
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h4;
    req_size[0] = HSIZE_WORD;
    req_size[1] = HSIZE_WORD;
    req_valid = 2'b11;
    ov0 = overlap_cnt;
    cyc = 0; ndone = 0; last_cyc = 0; cnt0 = 0; cnt1 = 0;
    while (cyc < 80 && ndone < 8) begin
      @(posedge HCLK);
      #1;
      cyc++;
      if (req_done != 2'b00) begin
        exp_done = (ndone % 2 == 0) ? 2'b01 : 2'b10;
        check($sformatf("rr order %0d", ndone), 32'(req_done), 32'(exp_done));
        if (ndone > 0) check($sformatf("rr spacing %0d", ndone), 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        ndone++;
        if (req_done[0]) cnt0++;
        if (req_done[1]) cnt1++;
        if (cnt0 == 4) req_valid[0] = 1'b0;
        if (cnt1 == 4) req_valid[1] = 1'b0;
      end
    end
    check("rr completions", 32'(ndone), 32'd8);
    check("rr overlap", 32'(overlap_cnt - ov0), 32'd0);
    req_valid = 2'b00;
    @(posedge HCLK);

    // Reset while the slave holds the data phase of a write from client 0.
    @(negedge HCLK);
    wait_cfg = 3;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'hC;
    req_size[0]  = HSIZE_WORD;
    req_wdata[0] = 32'h55AA55AA;
    req_valid = 2'b01;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    check("mid hwdata in data", HWDATA, 32'h55AA55AA);
    HRESET = 1'b1;
    req_valid = 2'b00;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    wait_cfg = 0;
    check("mid done", 32'(req_done), 32'h0);
    check("mid htrans", 32'(HTRANS), 32'(IDLE));
    check("mid haddr", HADDR, 32'h0);
    check("mid hwrite", 32'(HWRITE), 32'h0);
    check("mid hsize", 32'(HSIZE), 32'h0);
    check("mid hwdata", HWDATA, 32'h0);
    check("mid err", 32'(req_err), 32'h0);
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge HCLK);
      #1;
      if (req_done != 2'b00) saw_done = 1'b1;
    end
    check("mid no done after reset", 32'(saw_done), 32'h0);

    @(negedge HCLK);
    req_write = 2'b00;
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h4;
    req_valid = 2'b11;
    cyc = 0;
    while (cyc < 20 && req_done == 2'b00) begin
      @(posedge HCLK);
      #1;
      cyc++;
    end
    check("post reset first grant", 32'(req_done), 32'd1);
    req_valid = 2'b00;
    @(posedge HCLK);
    @(posedge HCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
